// File: rtl/mem_pkg.sv
// Shared definitions for the instruction/data memory arbiter: bus widths and
// the arbiter state encoding.
package mem_pkg;

  localparam int ADDR_W = 32;
  localparam int DATA_W = 32;
  localparam int MASK_W = 4;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    I_BUSY = 2'd1,
    D_BUSY = 2'd2
  } arb_state_t;

endpackage

// File: rtl/imem_dmem_arbiter.sv
// Shares one single-ported memory between instruction fetch and load/store,
// with a fixed priority side that is forced to yield after MAX_STREAK wins.
module imem_dmem_arbiter
  import mem_pkg::*;
#(
  parameter int DATA_PRIORITY = 1,
  parameter int MAX_STREAK    = 4
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              i_req,
  input  logic [ADDR_W-1:0] i_addr,
  output logic [DATA_W-1:0] i_rdata,
  output logic              i_valid,
  output logic              imem_stall,
  input  logic              flush,
  input  logic              d_req,
  input  logic              d_we,
  input  logic [ADDR_W-1:0] d_addr,
  input  logic [DATA_W-1:0] d_wdata,
  input  logic [MASK_W-1:0] d_wmask,
  output logic [DATA_W-1:0] d_rdata,
  output logic              d_valid,
  output logic              dmem_stall,
  output logic              m_req,
  output logic              m_we,
  output logic [ADDR_W-1:0] m_addr,
  output logic [DATA_W-1:0] m_wdata,
  output logic [MASK_W-1:0] m_wmask,
  input  logic              m_ack,
  input  logic [DATA_W-1:0] m_rdata
);

  localparam logic       DPRI       = (DATA_PRIORITY != 0);
  localparam logic [3:0] STREAK_MAX = 4'(MAX_STREAK);

  arb_state_t state;
  logic [3:0] streak;
  logic       drop;

  logic i_elig, d_elig, pri_elig, oth_elig;
  logic grant_pri, grant_oth, grant_i, grant_d;

  assign imem_stall = i_req & ~i_valid;
  assign dmem_stall = d_req & ~d_valid;

  // A side whose valid is pulsing this cycle has just been served and must not re-issue.
  always_comb begin
    i_elig    = i_req & ~i_valid;
    d_elig    = d_req & ~d_valid;
    pri_elig  = DPRI ? d_elig : i_elig;
    oth_elig  = DPRI ? i_elig : d_elig;
    grant_pri = pri_elig & ~(oth_elig & (streak == STREAK_MAX));
    grant_oth = oth_elig & ~grant_pri;
    grant_d   = DPRI ? grant_pri : grant_oth;
    grant_i   = DPRI ? grant_oth : grant_pri;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state   <= IDLE;
      m_req   <= 1'b0;
      m_we    <= 1'b0;
      m_addr  <= '0;
      m_wdata <= '0;
      m_wmask <= '0;
      i_valid <= 1'b0;
      d_valid <= 1'b0;
      i_rdata <= '0;
      d_rdata <= '0;
      streak  <= '0;
      drop    <= 1'b0;
    end else begin
      i_valid <= 1'b0;
      d_valid <= 1'b0;
      case (state)
        IDLE: begin
          // Streak only grows while the other side is actually waiting.
          if (grant_pri)
            streak <= oth_elig ? ((streak == STREAK_MAX) ? streak : streak + 4'd1) : 4'd0;
          else if (grant_oth)
            streak <= 4'd0;
          if (grant_d) begin
            state   <= D_BUSY;
            m_req   <= 1'b1;
            m_we    <= d_we;
            m_addr  <= d_addr;
            m_wdata <= d_wdata;
            m_wmask <= d_wmask;
          end else if (grant_i) begin
            state   <= I_BUSY;
            m_req   <= 1'b1;
            m_we    <= 1'b0;
            m_addr  <= i_addr;
            m_wdata <= '0;
            m_wmask <= '0;
          end
        end
        I_BUSY: begin
          // A flush on the ack cycle itself still suppresses the result.
          if (m_ack) begin
            state <= IDLE;
            m_req <= 1'b0;
            drop  <= 1'b0;
            if (!(drop | flush)) begin
              i_valid <= 1'b1;
              i_rdata <= m_rdata;
            end
          end else if (flush) begin
            drop <= 1'b1;
          end
        end
        D_BUSY: begin
          if (m_ack) begin
            state   <= IDLE;
            m_req   <= 1'b0;
            d_valid <= 1'b1;
            if (!m_we) d_rdata <= m_rdata;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule
